// File: rtl/alu_bitserial_seq.sv
// alu_bitserial_seq
// Bit-serial sequencer for an external 1-bit ALU slice. Feeds the slice one
// operand bit per cycle (LSB first), registers the ripple carry between
// cycles, resolves SLT from the final subtraction bit, and collects the
// WIDTH-bit result with carry/overflow/zero flags.
//
// Optional build macro: ALU_SEQ_ABORT_EN adds an 'abort' input that cancels
// an operation in RUN or FIN without producing done or touching the held
// result and flags.
//
// Handshake: start is a request sampled only while busy=0 (IDLE). There is
// no backpressure; once accepted, the operation runs for WIDTH cycles and
// then raises done for exactly one cycle, during which result and flags are
// already valid. They stay stable until the next operation completes.
module alu_bitserial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
`ifdef ALU_SEQ_ABORT_EN
    input  logic             abort,
`endif
    input  logic             start,
    input  logic [3:0]       ctl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic [3:0]       slice_ctl,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic             slice_slt,
    input  logic             slice_out,
    input  logic             slice_cout
);

    localparam int KW = $clog2(WIDTH);
    localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

    localparam logic [3:0] CTL_ADD = 4'd2;
    localparam logic [3:0] CTL_SUB = 4'd6;
    localparam logic [3:0] CTL_SLT = 4'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] r_sh;
    logic [3:0]       ctl_reg;
    logic             carry_reg;
    logic [KW-1:0]    k;

    // Values produced by the last RUN edge, shown during FIN.
    logic [WIDTH-1:0] fin_result;
    logic             fin_cout;
    logic             fin_ovf;
    logic             fin_zero;

    // Values committed when FIN completes; held between operations.
    logic [WIDTH-1:0] held_result;
    logic             held_cout;
    logic             held_ovf;
    logic             held_zero;

    logic             abort_now;
    logic             last_bit;
    logic             is_arith;
    logic             is_slt;
    logic             slt_set;
    logic [WIDTH-1:0] last_r;
    logic [WIDTH-1:0] final_r;

`ifdef ALU_SEQ_ABORT_EN
    assign abort_now = abort && (state != S_IDLE);
`else
    assign abort_now = 1'b0;
`endif

    // Decode of the operation in flight and the final-bit result assembly.
    always_comb begin
        last_bit = (state == S_RUN) && (k == K_LAST);
        is_arith = (ctl_reg == CTL_ADD) || (ctl_reg == CTL_SUB);
        is_slt   = (ctl_reg == CTL_SLT);
        // Sign of A-B corrected by overflow gives the signed A<B answer.
        slt_set  = slice_out ^ (carry_reg ^ slice_cout);
        last_r   = {slice_out, r_sh[WIDTH-1:1]};
        final_r  = is_slt ? {{(WIDTH-1){1'b0}}, slt_set} : last_r;
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic and the slice/handshake outputs.
    always_comb begin
        state_nx  = state;
        busy      = 1'b0;
        done      = 1'b0;
        slice_ctl = 4'd0;
        slice_a   = 1'b0;
        slice_b   = 1'b0;
        slice_cin = 1'b0;
        slice_slt = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_RUN;
                end
            end
            S_RUN: begin
                busy      = 1'b1;
                // SLT runs the slice as a subtraction; the set bit is
                // derived from the MSB outcome.
                slice_ctl = is_slt ? CTL_SUB : ctl_reg;
                slice_a   = a_sh[0];
                slice_b   = b_sh[0];
                slice_cin = carry_reg;
                if (abort_now) begin
                    state_nx = S_IDLE;
                end else if (k == K_LAST) begin
                    state_nx = S_FIN;
                end
            end
            S_FIN: begin
                done     = !abort_now;
                state_nx = S_IDLE;
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // Operand/result shift registers, carry register and bit counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_sh      <= '0;
            b_sh      <= '0;
            r_sh      <= '0;
            ctl_reg   <= 4'd0;
            carry_reg <= 1'b0;
            k         <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sh      <= op_a;
                        b_sh      <= op_b;
                        r_sh      <= '0;
                        ctl_reg   <= ctl;
                        carry_reg <= (ctl == CTL_SUB) || (ctl == CTL_SLT);
                        k         <= '0;
                    end
                end
                S_RUN: begin
                    if (abort_now) begin
                        a_sh      <= '0;
                        b_sh      <= '0;
                        r_sh      <= '0;
                        carry_reg <= 1'b0;
                        k         <= '0;
                    end else begin
                        a_sh      <= {1'b0, a_sh[WIDTH-1:1]};
                        b_sh      <= {1'b0, b_sh[WIDTH-1:1]};
                        r_sh      <= last_r;
                        carry_reg <= slice_cout;
                        k         <= k + 1'b1;
                    end
                end
                S_FIN: begin
                    if (abort_now) begin
                        a_sh      <= '0;
                        b_sh      <= '0;
                        r_sh      <= '0;
                        carry_reg <= 1'b0;
                        k         <= '0;
                    end
                end
                default: begin
                    k <= '0;
                end
            endcase
        end
    end

    // Capture the final result and flags on the last RUN edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fin_result <= '0;
            fin_cout   <= 1'b0;
            fin_ovf    <= 1'b0;
            fin_zero   <= 1'b0;
        end else if (last_bit && !abort_now) begin
            fin_result <= final_r;
            fin_cout   <= is_arith ? slice_cout : 1'b0;
            fin_ovf    <= is_arith ? (carry_reg ^ slice_cout) : 1'b0;
            fin_zero   <= (final_r == '0);
        end
    end

    // Commit the finished values when FIN completes without an abort.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_result <= '0;
            held_cout   <= 1'b0;
            held_ovf    <= 1'b0;
            held_zero   <= 1'b0;
        end else if ((state == S_FIN) && !abort_now) begin
            held_result <= fin_result;
            held_cout   <= fin_cout;
            held_ovf    <= fin_ovf;
            held_zero   <= fin_zero;
        end
    end

    // Result/flag outputs: new values are visible from the done cycle on.
    always_comb begin
        if (done) begin
            result    = fin_result;
            carry_out = fin_cout;
            overflow  = fin_ovf;
            zero      = fin_zero;
        end else begin
            result    = held_result;
            carry_out = held_cout;
            overflow  = held_ovf;
            zero      = held_zero;
        end
    end

endmodule

// File: tb/tb_alu_bitserial_seq.sv
// Testbench for alu_bitserial_seq (WIDTH=8) with a behavioural 1-bit slice.
module tb_alu_bitserial_seq;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [3:0]   ctl;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;
    logic         overflow;
    logic         zero;
    logic [3:0]   slice_ctl;
    logic         slice_a;
    logic         slice_b;
    logic         slice_cin;
    logic         slice_slt;
    logic         slice_out;
    logic         slice_cout;
`ifdef ALU_SEQ_ABORT_EN
    logic         abort;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // scoreboard: expected result, {carry,ovf,zero}, and done cycle
    logic [W-1:0] exp_q[$];
    logic [2:0]   flag_q[$];
    int           due_q[$];
    logic [3:0]   ctl_q[$];
    logic [W-1:0] held_res   = '0;
    logic [2:0]   held_flags = '0;

    alu_bitserial_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
`ifdef ALU_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .start      (start),
        .ctl        (ctl),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .carry_out  (carry_out),
        .overflow   (overflow),
        .zero       (zero),
        .slice_ctl  (slice_ctl),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_slt  (slice_slt),
        .slice_out  (slice_out),
        .slice_cout (slice_cout)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ---------------- 1-bit ALU slice model ----------------
    always_comb begin
        logic nb;
        nb         = ~slice_b;
        slice_out  = 1'b0;
        slice_cout = 1'b0;
        case (slice_ctl)
            4'd0:  slice_out = slice_a & slice_b;
            4'd1:  slice_out = slice_a | slice_b;
            4'd2: begin
                slice_out  = slice_a ^ slice_b ^ slice_cin;
                slice_cout = (slice_a & slice_b) | (slice_a & slice_cin) | (slice_b & slice_cin);
            end
            4'd6: begin
                slice_out  = slice_a ^ nb ^ slice_cin;
                slice_cout = (slice_a & nb) | (slice_a & slice_cin) | (nb & slice_cin);
            end
            4'd7: begin
                slice_out  = slice_slt;
                slice_cout = (slice_a & nb) | (slice_a & slice_cin) | (nb & slice_cin);
            end
            4'd12: slice_out = ~(slice_a | slice_b);
            default: begin
                slice_out  = 1'b0;
                slice_cout = 1'b0;
            end
        endcase
    end

    // ---------------- reference model (word level) ----------------
    function automatic void model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic cy, output logic ov,
                                  output logic z);
        logic [W:0] s;
        r  = '0;
        cy = 1'b0;
        ov = 1'b0;
        s  = '0;
        case (c)
            4'd0:  r = a & b;
            4'd1:  r = a | b;
            4'd12: r = ~(a | b);
            4'd2: begin
                s  = {1'b0, a} + {1'b0, b};
                r  = s[W-1:0];
                cy = s[W];
                ov = (a[W-1] == b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'd6: begin
                s  = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                r  = s[W-1:0];
                cy = s[W];
                ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
            end
            4'd7:  r = ($signed(a) < $signed(b)) ? W'(1) : W'(0);
            default: r = '0;
        endcase
        z = (r == '0);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic cy, ov, z;
        @(negedge clk);
        ctl   = c;
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        model(c, a, b, r, cy, ov, z);
        exp_q.push_back(r);
        flag_q.push_back({cy, ov, z});
        due_q.push_back(cyc + W);
        ctl_q.push_back(c);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL timeout: done not seen within 40 cycles");
            exp_q.delete();
            flag_q.delete();
            due_q.delete();
            ctl_q.delete();
        end
    endtask

    // directed op with hand-computed expectations that also pin the model
    task automatic run_op(input string name, input logic [3:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] hr, input logic hc,
                          input logic hv, input logic hz);
        logic [W-1:0] r;
        logic cy, ov, z;
        model(c, a, b, r, cy, ov, z);
        chk({name, "_model"}, {r, cy, ov, z}, {hr, hc, hv, hz});
        issue(c, a, b);
        wait_idle();
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!reset) begin
            bit exp_done, exp_busy;
            exp_done = (due_q.size() > 0) && (cyc == due_q[0]);
            exp_busy = (due_q.size() > 0) && (cyc < due_q[0]);
            chk("done", done, exp_done);
            chk("busy", busy, exp_busy);
            if (exp_busy) begin
                chk("slice_ctl_run", slice_ctl, (ctl_q[0] == 4'd7) ? 4'd6 : ctl_q[0]);
                chk("slice_slt_run", slice_slt, 0);
            end else begin
                chk("slice_idle", {slice_ctl, slice_a, slice_b, slice_cin, slice_slt}, 0);
            end
            if (exp_done) begin
                chk("result", result, exp_q[0]);
                chk("flags", {carry_out, overflow, zero}, flag_q[0]);
                held_res   = exp_q.pop_front();
                held_flags = flag_q.pop_front();
                void'(due_q.pop_front());
                void'(ctl_q.pop_front());
            end else begin
                chk("result_held", result, held_res);
                chk("flags_held", {carry_out, overflow, zero}, held_flags);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0] ctls[6];
        ctls = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12};
        reset = 1'b1;
        start = 1'b0;
        ctl   = 4'd0;
        op_a  = '0;
        op_b  = '0;
`ifdef ALU_SEQ_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("reset_outputs", {busy, done, result, carry_out, overflow, zero}, 0);
        chk("reset_slice", {slice_ctl, slice_a, slice_b, slice_cin, slice_slt}, 0);
        reset = 1'b0;
        @(negedge clk);

        run_op("add_7f_01",  4'd2,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
        run_op("sub_05_05",  4'd6,  8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("slt_80_01",  4'd7,  8'h80, 8'h01, 8'h01, 1'b0, 1'b0, 1'b0);
        run_op("slt_01_80",  4'd7,  8'h01, 8'h80, 8'h00, 1'b0, 1'b0, 1'b1);
        run_op("nor_f0_0c",  4'd12, 8'hF0, 8'h0C, 8'h03, 1'b0, 1'b0, 1'b0);
        run_op("add_ff_01",  4'd2,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op("sub_01_02",  4'd6,  8'h01, 8'h02, 8'hFF, 1'b0, 1'b0, 1'b0);
        run_op("sub_80_01",  4'd6,  8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
        run_op("unsup_3",    4'd3,  8'hA5, 8'h5A, 8'h00, 1'b0, 1'b0, 1'b1);
        run_op("slt_ff_fe",  4'd7,  8'hFF, 8'hFE, 8'h00, 1'b0, 1'b0, 1'b1);

        // AND with a second start pulsed mid-RUN: must be ignored
        begin
            logic [W-1:0] r;
            logic cy, ov, z;
            model(4'd0, 8'hF0, 8'h3C, r, cy, ov, z);
            chk("and_f0_3c_model", r, 8'h30);
        end
        issue(4'd0, 8'hF0, 8'h3C);
        repeat (3) @(negedge clk);
        ctl   = 4'd2;
        op_a  = 8'h11;
        op_b  = 8'h22;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // reset asserted during RUN at k=4
        issue(4'd2, 8'h33, 8'h44);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrun_reset_outputs", {busy, done, result, carry_out, overflow, zero}, 0);
        chk("midrun_reset_slice", {slice_ctl, slice_a, slice_b, slice_cin, slice_slt}, 0);
        exp_q.delete();
        flag_q.delete();
        due_q.delete();
        ctl_q.delete();
        held_res   = '0;
        held_flags = '0;
        @(negedge clk);
        reset = 1'b0;
        run_op("or_0a_50", 4'd1, 8'h0A, 8'h50, 8'h5A, 1'b0, 1'b0, 1'b0);

`ifdef ALU_SEQ_ABORT_EN
        // abort at k=3: no done, result stays 0x5A, idle next cycle
        issue(4'd2, 8'h12, 8'h34);
        repeat (4) @(negedge clk);
        #1;
        exp_q.delete();
        flag_q.delete();
        due_q.delete();
        ctl_q.delete();
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_result", result, 8'h5A);
        repeat (W + 2) @(negedge clk);
        chk("abort_result_later", result, 8'h5A);
`endif

        // a few random ops checked against the model
        for (int i = 0; i < 6; i++) begin
            issue(ctls[$urandom_range(0, 5)], W'($urandom_range(0, 255)), W'($urandom_range(0, 255)));
            wait_idle();
        end

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
